// File: rtl/station_pkg.sv
// Shared item codes, FSM state encoding and station geometry for the kitchen game.
// Also holds the station priority helper used when several occupancy flags are high.
package station_pkg;

  localparam logic [1:0] ITEM_NONE    = 2'd0;
  localparam logic [1:0] ITEM_RAW     = 2'd1;
  localparam logic [1:0] ITEM_CHOPPED = 2'd2;

  typedef enum logic [1:0] {
    ST_EMPTY        = 2'd0,
    ST_HOLD_RAW     = 2'd1,
    ST_CHOPPING     = 2'd2,
    ST_HOLD_CHOPPED = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    STN_NONE  = 2'd0,
    STN_ONION = 2'd1,
    STN_CHOP  = 2'd2,
    STN_SERVE = 2'd3
  } station_t;

  // Default station rectangles in screen pixels, shared with the drawer/checkers.
  localparam int STATION_W = 64;
  localparam int STATION_H = 64;
  localparam int ONION_X   = 64;
  localparam int ONION_Y   = 96;
  localparam int CHOP_X    = 288;
  localparam int CHOP_Y    = 96;
  localparam int SERVE_X   = 512;
  localparam int SERVE_Y   = 96;

  function automatic station_t select_station(input logic onion, input logic chop,
                                              input logic serve);
    if (onion) return STN_ONION;
    if (chop)  return STN_CHOP;
    if (serve) return STN_SERVE;
    return STN_NONE;
  endfunction

endpackage

// File: rtl/chop_timer.sv
// Chop prescaler and step counter; counts only while run is high, cleared by start.
// done flags the edge on which the final step completes.
module chop_timer #(
  parameter int CHOP_TICKS = 2_500_000,
  parameter int CHOP_STEPS = 10,
  parameter int PROG_W     = 4
) (
  input  logic              clk_25MHz,
  input  logic              rst_n,
  input  logic              start,
  input  logic              run,
  output logic [PROG_W-1:0] progress,
  output logic              done
);

  localparam int                PRE_W     = (CHOP_TICKS > 1) ? $clog2(CHOP_TICKS) : 1;
  localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(CHOP_TICKS - 1);
  localparam logic [PROG_W-1:0] PROG_LAST = PROG_W'(CHOP_STEPS - 1);

  logic [PRE_W-1:0]  prescaler_reg, prescaler_next;
  logic [PROG_W-1:0] progress_reg, progress_next;
  logic              tick;

  assign tick     = run && (prescaler_reg == PRE_LAST);
  assign done     = tick && (progress_reg == PROG_LAST);
  assign progress = progress_reg;

  always_comb begin
    prescaler_next = prescaler_reg;
    progress_next  = progress_reg;
    if (start) begin
      prescaler_next = '0;
      progress_next  = '0;
    end else if (tick) begin
      prescaler_next = '0;
      progress_next  = progress_reg + PROG_W'(1);
    end else if (run) begin
      prescaler_next = prescaler_reg + PRE_W'(1);
    end
  end

  always_ff @(posedge clk_25MHz or negedge rst_n) begin
    if (!rst_n) begin
      prescaler_reg <= '0;
      progress_reg  <= '0;
    end else begin
      prescaler_reg <= prescaler_next;
      progress_reg  <= progress_next;
    end
  end

endmodule

// File: rtl/station_interact_fsm.sv
// Carried-item FSM, chop sequencing and served-dish score for the kitchen stations.
// Define STATION_DROP_EN to let a press away from every station discard the held item.
module station_interact_fsm
  import station_pkg::*;
#(
  parameter int CHOP_TICKS = 2_500_000,
  parameter int CHOP_STEPS = 10,
  parameter int SCORE_W    = 8
) (
  input  logic               clk_25MHz,
  input  logic               rst_n,
  input  logic               in_onion,
  input  logic               in_chop,
  input  logic               in_serve,
  input  logic               btn_pulse,
  output logic [1:0]         held_item,
  output logic               chop_busy,
  output logic [3:0]         chop_progress,
  output logic               chop_done,
  output logic               serve_pulse,
  output logic [SCORE_W-1:0] score
);

  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

  state_t             state_reg;
  logic [1:0]         held_item_reg;
  logic               chop_busy_reg;
  logic               chop_done_reg;
  logic               serve_pulse_reg;
  logic [SCORE_W-1:0] score_reg;

  station_t station;
  logic     take_or_return, start_chop, serve_now, drop_now;
  logic     timer_start, timer_done;

  assign station        = select_station(in_onion, in_chop, in_serve);
  assign take_or_return = btn_pulse && (station == STN_ONION);
  assign start_chop     = btn_pulse && (state_reg == ST_HOLD_RAW) && (station == STN_CHOP);
  assign serve_now      = btn_pulse && (state_reg == ST_HOLD_CHOPPED) && (station == STN_SERVE);
`ifdef STATION_DROP_EN
  assign drop_now = btn_pulse && (station == STN_NONE) &&
                    ((state_reg == ST_HOLD_RAW) || (state_reg == ST_HOLD_CHOPPED));
`else
  assign drop_now = 1'b0;
`endif

  // Clearing on every exit from HOLD_CHOPPED makes progress read 0 on the same edge EMPTY is entered.
  assign timer_start = start_chop || serve_now || drop_now;

  chop_timer #(
    .CHOP_TICKS(CHOP_TICKS),
    .CHOP_STEPS(CHOP_STEPS),
    .PROG_W    (4)
  ) u_chop_timer (
    .clk_25MHz(clk_25MHz),
    .rst_n    (rst_n),
    .start    (timer_start),
    .run      (chop_busy_reg && in_chop),
    .progress (chop_progress),
    .done     (timer_done)
  );

  always_ff @(posedge clk_25MHz or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= ST_EMPTY;
      held_item_reg   <= ITEM_NONE;
      chop_busy_reg   <= 1'b0;
      chop_done_reg   <= 1'b0;
      serve_pulse_reg <= 1'b0;
      score_reg       <= '0;
    end else begin
      chop_done_reg   <= 1'b0;
      serve_pulse_reg <= 1'b0;
      case (state_reg)
        ST_EMPTY: begin
          if (take_or_return) begin
            state_reg     <= ST_HOLD_RAW;
            held_item_reg <= ITEM_RAW;
          end
        end
        ST_HOLD_RAW: begin
          if (take_or_return || drop_now) begin
            state_reg     <= ST_EMPTY;
            held_item_reg <= ITEM_NONE;
          end else if (start_chop) begin
            state_reg     <= ST_CHOPPING;
            chop_busy_reg <= 1'b1;
          end
        end
        ST_CHOPPING: begin
          if (timer_done) begin
            state_reg     <= ST_HOLD_CHOPPED;
            held_item_reg <= ITEM_CHOPPED;
            chop_busy_reg <= 1'b0;
            chop_done_reg <= 1'b1;
          end
        end
        ST_HOLD_CHOPPED: begin
          if (serve_now) begin
            state_reg       <= ST_EMPTY;
            held_item_reg   <= ITEM_NONE;
            serve_pulse_reg <= 1'b1;
            if (score_reg != SCORE_MAX) score_reg <= score_reg + SCORE_W'(1);
          end else if (drop_now) begin
            state_reg     <= ST_EMPTY;
            held_item_reg <= ITEM_NONE;
          end
        end
        default: begin
          state_reg     <= ST_EMPTY;
          held_item_reg <= ITEM_NONE;
          chop_busy_reg <= 1'b0;
        end
      endcase
    end
  end

  assign held_item   = held_item_reg;
  assign chop_busy   = chop_busy_reg;
  assign chop_done   = chop_done_reg;
  assign serve_pulse = serve_pulse_reg;
  assign score       = score_reg;

endmodule

// File: tb/tb_station_interact_fsm.sv
// Scoreboard bench: a cycle-level reference model predicts output events, a monitor checks them.
module tb_station_interact_fsm;

  localparam int CHOP_TICKS = 4;
  localparam int CHOP_STEPS = 3;
  localparam int SCORE_W    = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic in_onion = 1'b0, in_chop = 1'b0, in_serve = 1'b0, btn_pulse = 1'b0;
  logic [1:0]         held_item;
  logic               chop_busy;
  logic [3:0]         chop_progress;
  logic               chop_done;
  logic               serve_pulse;
  logic [SCORE_W-1:0] score;

  station_interact_fsm #(
    .CHOP_TICKS(CHOP_TICKS),
    .CHOP_STEPS(CHOP_STEPS),
    .SCORE_W   (SCORE_W)
  ) dut (
    .clk_25MHz    (clk),
    .rst_n        (rst_n),
    .in_onion     (in_onion),
    .in_chop      (in_chop),
    .in_serve     (in_serve),
    .btn_pulse    (btn_pulse),
    .held_item    (held_item),
    .chop_busy    (chop_busy),
    .chop_progress(chop_progress),
    .chop_done    (chop_done),
    .serve_pulse  (serve_pulse),
    .score        (score)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int errors = 0;
  int checks = 0;

  // event vector: {busy, held[1:0], progress[3:0], score, done, serve}
  localparam int SW = 7 + SCORE_W;
  typedef struct {
    int          cyc;
    logic [SW+1:0] v;
  } ev_t;
  ev_t exp_q[$];

  // Reference model: carried item, remaining work measured in in_chop cycles, dish count.
  int m_item, m_chop, m_work, m_score;
  logic [SW-1:0] m_last_s;

  task automatic model_reset();
    m_item = 0; m_chop = 0; m_work = 0; m_score = 0; m_last_s = '0;
  endtask

  function automatic logic [SW-1:0] model_state();
    int held, prog;
    held = m_chop ? 1 : m_item;
    if (m_chop != 0)      prog = m_work / CHOP_TICKS;
    else if (m_item == 2) prog = CHOP_STEPS;
    else                  prog = 0;
    return {1'(m_chop), 2'(held), 4'(prog), SCORE_W'(m_score)};
  endfunction

  task automatic model_edge(input bit o, input bit c, input bit s, input bit b);
    bit done, srv;
    logic [SW-1:0] st;
    ev_t e;
    done = 0; srv = 0;
    if (m_chop != 0) begin
      if (c) begin
        m_work++;
        if (m_work == CHOP_TICKS * CHOP_STEPS) begin
          m_chop = 0; m_item = 2; done = 1;
        end
      end
    end else if (b) begin
      if (o) begin
        if (m_item == 0) m_item = 1;
        else if (m_item == 1) m_item = 0;
      end else if (c) begin
        if (m_item == 1) begin m_chop = 1; m_work = 0; end
      end else if (s) begin
        if (m_item == 2) begin
          m_item = 0; srv = 1;
          if (m_score < (1 << SCORE_W) - 1) m_score++;
        end
      end else begin
`ifdef STATION_DROP_EN
        m_item = 0;
`endif
      end
    end
    st = model_state();
    if (st != m_last_s || done || srv) begin
      e.cyc = cyc + 1;
      e.v   = {st, done, srv};
      exp_q.push_back(e);
    end
    m_last_s = st;
  endtask

  task automatic step(input bit o, input bit c, input bit s, input bit b);
    @(negedge clk);
    in_onion = o; in_chop = c; in_serve = s; btn_pulse = b;
    if (rst_n) model_edge(o, c, s, b);
  endtask

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s got=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_held"}, int'(held_item), 0);
    chk({tag, "_busy"}, int'(chop_busy), 0);
    chk({tag, "_prog"}, int'(chop_progress), 0);
    chk({tag, "_done"}, int'(chop_done), 0);
    chk({tag, "_serve"}, int'(serve_pulse), 0);
    chk({tag, "_score"}, int'(score), 0);
  endtask

  // Monitor: any change of held state or any pulse is one DUT transaction.
  logic [SW-1:0] last_s = '0;
  always @(negedge clk) begin
    logic [SW-1:0] cur_s;
    logic [SW+1:0] obs;
    ev_t e;
    if (!rst_n) begin
      last_s = '0;
    end else begin
      cur_s = {chop_busy, held_item, chop_progress, score};
      if (cur_s != last_s || chop_done || serve_pulse) begin
        obs = {cur_s, chop_done, serve_pulse};
        checks++;
        $display("cyc=%0d busy=%0d held=%0d prog=%0d score=%0d done=%0d serve=%0d",
                 cyc, chop_busy, held_item, chop_progress, score, chop_done, serve_pulse);
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL event_unexpected cyc=%0d got=%h required=none", cyc, obs);
        end else begin
          e = exp_q.pop_front();
          if (e.cyc != cyc || e.v !== obs) begin
            errors++;
            $display("FAIL event got cyc=%0d val=%h required cyc=%0d val=%h", cyc, obs, e.cyc, e.v);
          end
        end
        last_s = cur_s;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL timeout got=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    model_reset();
    #2 rst_n = 1'b0;
    #1 check_zero("reset_async");
    repeat (3) step(1, 0, 0, 1);
    check_zero("reset_hold");
    @(negedge clk);
    btn_pulse = 1'b0; in_onion = 1'b0;
    rst_n = 1'b1;
    model_reset();

    // pick up onion, then a press with no station
    step(1, 0, 0, 1);
    step(1, 0, 0, 0);
    step(0, 0, 0, 1);
`ifdef STATION_DROP_EN
    step(1, 0, 0, 1);
`endif
    // uninterrupted chop
    step(0, 1, 0, 1);
    repeat (14) step(0, 1, 0, 0);
    // serve repeatedly until the score saturates
    repeat (4) begin
      step(0, 0, 1, 1);
      step(1, 0, 0, 1);
      step(0, 1, 0, 1);
      repeat (13) step(0, 1, 0, 0);
    end
    step(0, 0, 1, 1);
    // paused chop with ignored presses during the pause
    step(1, 0, 0, 1);
    step(0, 1, 0, 1);
    repeat (6) step(0, 1, 0, 0);
    repeat (8) step(0, 0, 0, 0);
    step(1, 0, 0, 1);
    step(0, 0, 1, 1);
    repeat (10) step(0, 0, 0, 0);
    repeat (8) step(0, 1, 0, 0);
    // reset in the middle of a chop
    step(0, 0, 1, 1);
    step(1, 0, 0, 1);
    step(0, 1, 0, 1);
    repeat (5) step(0, 1, 0, 0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_zero("reset_midchop");
    repeat (2) step(1, 0, 0, 1);
    check_zero("reset_btn_ignored");
    @(negedge clk);
    btn_pulse = 1'b0; in_onion = 1'b0;
    rst_n = 1'b1;
    model_reset();
    step(0, 0, 0, 0);
    // randomized play
    repeat (1500) begin
      step($urandom_range(0, 9) == 0, $urandom_range(0, 9) < 6,
           $urandom_range(0, 9) < 3, $urandom_range(0, 5) == 0);
    end
    repeat (4) step(0, 0, 0, 0);
    chk("pending_events", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
